// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

  // Top FSM state encoding
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCredit = 2'd1,
    StVend   = 2'd2,
    StChange = 2'd3
  } vend_state_e;

  // Coin codes on CN
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A_C  = 2'b01;
  localparam logic [1:0] COIN_B_C  = 2'b10;
  localparam logic [1:0] COIN_C_C  = 2'b11;

endpackage

// File: rtl/vend_stm_multi_if.sv
// Customer/delivery/change signal bundle for vend_stm_multi.
// RESTOCK/EMPTY exist only when VEND_STOCK_COUNT_EN is defined.
interface vend_stm_multi_if #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CREDIT_W = 8
`ifdef VEND_STOCK_COUNT_EN
  ,
  parameter int unsigned N_ITEMS  = 4
`endif
);
  logic                ST;
  logic [1:0]          CN;
  logic                FS;
  logic [SEL_W-1:0]    SEL;
  logic                CAN;
  logic                FD;
  logic [SEL_W-1:0]    FD_ITEM;
  logic                CHG;
  logic [CREDIT_W-1:0] CHG_AMT;
  logic                REJ;
  logic                DENY;
  logic [CREDIT_W-1:0] CREDIT;
`ifdef VEND_STOCK_COUNT_EN
  logic                RESTOCK;
  logic [N_ITEMS-1:0]  EMPTY;

  modport master (output ST, CN, FS, SEL, CAN, RESTOCK,
                  input FD, FD_ITEM, CHG, CHG_AMT, REJ, DENY, CREDIT, EMPTY);
  modport slave  (input ST, CN, FS, SEL, CAN, RESTOCK,
                  output FD, FD_ITEM, CHG, CHG_AMT, REJ, DENY, CREDIT, EMPTY);
`else
  modport master (output ST, CN, FS, SEL, CAN,
                  input FD, FD_ITEM, CHG, CHG_AMT, REJ, DENY, CREDIT);
  modport slave  (input ST, CN, FS, SEL, CAN,
                  output FD, FD_ITEM, CHG, CHG_AMT, REJ, DENY, CREDIT);
`endif
endinterface

// File: rtl/vend_coin_decode.sv
// Combinational coin-code decoder: CN -> coin value plus valid flag.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned COIN_A   = 5,
  parameter int unsigned COIN_B   = 10,
  parameter int unsigned COIN_C   = 25
) (
  input  logic [1:0]          i_cn,
  output logic [CREDIT_W-1:0] o_value,
  output logic                o_valid
);

  // Map each coin code to its value
  always_comb begin
    o_value = '0;
    o_valid = 1'b0;
    unique case (i_cn)
      COIN_NONE: ;
      COIN_A_C: begin o_value = CREDIT_W'(COIN_A); o_valid = 1'b1; end
      COIN_B_C: begin o_value = CREDIT_W'(COIN_B); o_valid = 1'b1; end
      COIN_C_C: begin o_value = CREDIT_W'(COIN_C); o_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/vend_stm_multi.sv
// Multi-item vending controller: credit, vend, change, cancel and coin rejection.
// Optional per-item stock counting under macro VEND_STOCK_COUNT_EN.
module vend_stm_multi
  import vend_pkg::*;
#(
  parameter int unsigned                   N_ITEMS    = 4,
  parameter int unsigned                   SEL_W      = 2,
  parameter int unsigned                   CREDIT_W   = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICES     = {8'd40, 8'd30, 8'd25, 8'd15},
  parameter int unsigned                   COIN_A     = 5,
  parameter int unsigned                   COIN_B     = 10,
  parameter int unsigned                   COIN_C     = 25,
  parameter int unsigned                   MAX_CREDIT = 100
) (
  input logic             CLK,
  input logic             RST,
  vend_stm_multi_if.slave bus
);

  vend_state_e         r_state, w_state_d;
  logic [CREDIT_W-1:0] r_credit, w_credit_d, r_chg_amt, w_chg_amt_d;
  logic [CREDIT_W-1:0] w_coin_val, w_price;
  logic [CREDIT_W:0]   w_sum;
  logic [SEL_W-1:0]    r_fd_item, w_fd_item_d;
  logic                r_fd, w_fd_d, r_chg, w_chg_d, r_rej, w_rej_d, r_deny, w_deny_d;
  logic                w_coin_vld, w_sel_ok, w_stock_ok, w_taken, w_vend_go;

  vend_coin_decode #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B),
    .COIN_C   (COIN_C)
  ) u_coin (
    .i_cn    (bus.CN),
    .o_value (w_coin_val),
    .o_valid (w_coin_vld)
  );

  // Extra bit keeps the over-credit compare from wrapping
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

  // Price lookup; out-of-range selections are flagged invalid
  always_comb begin
    w_price  = '0;
    w_sel_ok = 1'b0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (bus.SEL == SEL_W'(i)) begin
        w_price  = PRICES[i*CREDIT_W +: CREDIT_W];
        w_sel_ok = 1'b1;
      end
    end
  end

`ifdef VEND_STOCK_COUNT_EN
  logic [3:0]         r_stock [N_ITEMS];
  logic [3:0]         w_stock_d [N_ITEMS];
  logic [N_ITEMS-1:0] r_empty;

  // Stock availability for the selected item plus next-state counters
  always_comb begin
    w_stock_ok = 1'b0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      w_stock_d[i] = r_stock[i];
      if (bus.SEL == SEL_W'(i)) w_stock_ok = (r_stock[i] != 4'd0);
      if (r_state == StIdle && bus.RESTOCK) begin
        w_stock_d[i] = 4'd15;
      end else if (w_vend_go && bus.SEL == SEL_W'(i)) begin
        w_stock_d[i] = r_stock[i] - 4'd1;
      end
    end
  end

  // Stock counters and registered empty flags
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (RST) begin
        r_stock[i] <= 4'd15;
        r_empty[i] <= 1'b0;
      end else begin
        r_stock[i] <= w_stock_d[i];
        r_empty[i] <= (w_stock_d[i] == 4'd0);
      end
    end
  end

  assign bus.EMPTY = r_empty;
`else
  assign w_stock_ok = 1'b1;
`endif

  // Next state and next registered outputs; priority CAN > FS > coin
  always_comb begin
    w_state_d   = r_state;
    w_credit_d  = r_credit;
    w_fd_d      = 1'b0;
    w_fd_item_d = '0;
    w_chg_d     = 1'b0;
    w_chg_amt_d = '0;
    w_rej_d     = 1'b0;
    w_deny_d    = 1'b0;
    w_taken     = 1'b0;
    w_vend_go   = 1'b0;
    unique case (r_state)
      StIdle, StCredit: begin
        if (r_state == StCredit && bus.CAN) begin
          w_state_d   = StChange;
          w_chg_d     = 1'b1;
          w_chg_amt_d = r_credit;
          w_credit_d  = '0;
          w_taken     = 1'b1;
        end else if (bus.ST && bus.FS) begin
          if (r_state == StIdle || !w_sel_ok || !w_stock_ok || r_credit < w_price) begin
            w_deny_d = 1'b1;
          end else begin
            w_state_d   = StVend;
            w_credit_d  = r_credit - w_price;
            w_fd_d      = 1'b1;
            w_fd_item_d = bus.SEL;
            w_taken     = 1'b1;
            w_vend_go   = 1'b1;
          end
        end
        // A coin alongside an accepted CAN/FS is handed back
        if (w_coin_vld) begin
          if (w_taken || !bus.ST || w_sum > (CREDIT_W+1)'(MAX_CREDIT)) begin
            w_rej_d = 1'b1;
          end else begin
            w_credit_d = w_sum[CREDIT_W-1:0];
            w_state_d  = StCredit;
          end
        end
      end
      StVend: begin
        w_state_d   = StChange;
        w_chg_d     = (r_credit != '0);
        w_chg_amt_d = r_credit;
        w_credit_d  = '0;
        w_rej_d     = w_coin_vld;
      end
      StChange: begin
        w_state_d = StIdle;
        w_rej_d   = w_coin_vld;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_credit  <= '0;
      r_fd      <= 1'b0;
      r_fd_item <= '0;
      r_chg     <= 1'b0;
      r_chg_amt <= '0;
      r_rej     <= 1'b0;
      r_deny    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_credit  <= w_credit_d;
      r_fd      <= w_fd_d;
      r_fd_item <= w_fd_item_d;
      r_chg     <= w_chg_d;
      r_chg_amt <= w_chg_amt_d;
      r_rej     <= w_rej_d;
      r_deny    <= w_deny_d;
    end
  end

  assign bus.FD      = r_fd;
  assign bus.FD_ITEM = r_fd_item;
  assign bus.CHG     = r_chg;
  assign bus.CHG_AMT = r_chg_amt;
  assign bus.REJ     = r_rej;
  assign bus.DENY    = r_deny;
  assign bus.CREDIT  = r_credit;

endmodule

// File: tb/tb_vend_stm_multi.sv
// Self-checking bench for vend_stm_multi with a transaction-level reference model.
// Also covers stock counting when VEND_STOCK_COUNT_EN is defined.
module tb_vend_stm_multi;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  vend_stm_multi_if #(
    .SEL_W    (2),
    .CREDIT_W (8)
`ifdef VEND_STOCK_COUNT_EN
    ,
    .N_ITEMS  (4)
`endif
  ) bus ();

  vend_stm_multi #(
    .N_ITEMS    (4),
    .SEL_W      (2),
    .CREDIT_W   (8),
    .PRICES     ({8'd40, 8'd30, 8'd25, 8'd15}),
    .COIN_A     (5),
    .COIN_B     (10),
    .COIN_C     (25),
    .MAX_CREDIT (100)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: price table, money held, and pending post-sale work
  int prices [4] = '{15, 25, 30, 40};
  int m_credit = 0;
  int m_phase  = 0;     // 0 ready, 1 goods just dispensed, 2 paying out
  int m_stock [4] = '{15, 15, 15, 15};
  bit e_fd, e_chg, e_rej, e_deny;
  int e_item, e_amt;

  function automatic int coin_value(input logic [1:0] cn);
    case (cn)
      2'd1:    return 5;
      2'd2:    return 10;
      2'd3:    return 25;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit st, input logic [1:0] cn, input bit fs,
                            input int sel, input bit can, input bit restock);
    bit took = 0;
    int v = coin_value(cn);
    {e_fd, e_chg, e_rej, e_deny} = '0;
    e_item = 0;
    e_amt  = 0;
    if (rst) begin
      m_credit = 0;
      m_phase  = 0;
      foreach (m_stock[i]) m_stock[i] = 15;
    end else if (m_phase == 1) begin
      e_chg    = (m_credit > 0);
      e_amt    = m_credit;
      m_credit = 0;
      m_phase  = 2;
      e_rej    = (cn != 0);
    end else if (m_phase == 2) begin
      m_phase = 0;
      e_rej   = (cn != 0);
    end else begin
`ifdef VEND_STOCK_COUNT_EN
      if (restock && m_credit == 0) foreach (m_stock[i]) m_stock[i] = 15;
`endif
      if (can && m_credit > 0) begin
        e_chg    = 1;
        e_amt    = m_credit;
        m_credit = 0;
        m_phase  = 2;
        took     = 1;
      end else if (st && fs) begin
        if (m_credit == 0 || sel >= 4 || m_credit < prices[sel]
`ifdef VEND_STOCK_COUNT_EN
            || m_stock[sel] == 0
`endif
           ) begin
          e_deny = 1;
        end else begin
          e_fd     = 1;
          e_item   = sel;
          m_credit = m_credit - prices[sel];
          m_phase  = 1;
          took     = 1;
`ifdef VEND_STOCK_COUNT_EN
          m_stock[sel]--;
`endif
        end
      end
      if (cn != 0) begin
        if (took || !st || m_credit + v > 100) e_rej = 1;
        else m_credit = m_credit + v;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    return {e_fd, 2'(e_item), e_chg, 8'(e_amt), e_rej, e_deny, 8'(m_credit)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.FD, bus.FD_ITEM, bus.CHG, bus.CHG_AMT, bus.REJ, bus.DENY, bus.CREDIT};
  endfunction

  // One clock of stimulus; the model advances alongside, outputs settle by #1 after the edge
  task automatic cyc(input bit rst, input bit st, input logic [1:0] cn, input bit fs,
                     input int sel, input bit can, input bit restock = 0);
    RST     = rst;
    bus.ST  = st;
    bus.CN  = cn;
    bus.FS  = fs;
    bus.SEL = 2'(sel);
    bus.CAN = can;
`ifdef VEND_STOCK_COUNT_EN
    bus.RESTOCK = restock;
`endif
    model_step(rst, st, cn, fs, sel, can, restock);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 2'd3, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 2'd2, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== 22'd0) begin
        n_err++;
        $display("FAIL reset_hold%0d got=%h want=0", i, dut_vec());
      end
    end
  endtask

  task automatic test_basic_vend();
    cyc(0, 1, 2'd2, 0, 0, 0);
    n_cmp++;
    if (bus.CREDIT !== 8'd10) begin
      n_err++; $display("FAIL basic_credit10 got=%0d want=10", bus.CREDIT);
    end
    cyc(0, 1, 2'd3, 0, 0, 0);
    n_cmp++;
    if (bus.CREDIT !== 8'd35) begin
      n_err++; $display("FAIL basic_credit35 got=%0d want=35", bus.CREDIT);
    end
    cyc(0, 1, 2'd0, 1, 2, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.FD !== 1'b1 || bus.FD_ITEM !== 2'd2) begin
      n_err++; $display("FAIL basic_fd got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.CHG_AMT !== 8'd5 || bus.CREDIT !== 8'd0) begin
      n_err++; $display("FAIL basic_chg got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 22'd0) begin
      n_err++; $display("FAIL basic_idle got=%h want=0", dut_vec());
    end
    // Exact price: FD, then nothing to pay out
    cyc(0, 1, 2'd3, 0, 0, 0);
    cyc(0, 1, 2'd0, 1, 1, 0);
    cyc(0, 1, 2'd0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.CHG !== 1'b0) begin
      n_err++; $display("FAIL exact_nochg got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
  endtask

  task automatic test_deny();
    cyc(0, 1, 2'd0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.DENY !== 1'b1) begin
      n_err++; $display("FAIL deny_idle got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd2, 0, 0, 0);
    cyc(0, 1, 2'd0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.DENY !== 1'b1 || bus.CREDIT !== 8'd10) begin
      n_err++; $display("FAIL deny_short got=%h want=%h", dut_vec(), exp_vec());
    end
    // Denied FS with coin: coin still counts
    cyc(0, 1, 2'd1, 1, 3, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL deny_coin got=%h want=%h", dut_vec(), exp_vec());
    end
    // ST=0: coin rejected, FS silently ignored
    cyc(0, 0, 2'd2, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL st_off got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 0, 2'd0, 0, 0, 1);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL cancel_st_off got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
  endtask

  task automatic test_overcredit();
    logic [1:0] coins [5] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1};
    foreach (coins[i]) cyc(0, 1, coins[i], 0, 0, 0);
    cyc(0, 1, 2'd3, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.REJ !== 1'b1 || bus.CREDIT !== 8'd90) begin
      n_err++; $display("FAIL over_rej got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd2, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.CREDIT !== 8'd100) begin
      n_err++; $display("FAIL over_max got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd1, 1, 3, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.FD !== 1'b1 || bus.REJ !== 1'b1) begin
      n_err++; $display("FAIL over_fd_rej got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.CHG_AMT !== 8'd60) begin
      n_err++; $display("FAIL over_chg got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
  endtask

  task automatic test_cancel_abort();
    cyc(0, 1, 2'd3, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 0, 0);
    cyc(0, 1, 2'd0, 1, 0, 1);
    n_cmp++;
    if (dut_vec() !== exp_vec() || bus.FD !== 1'b0 || bus.CHG_AMT !== 8'd35) begin
      n_err++; $display("FAIL cancel_fs got=%h want=%h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 2'd3, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 0, 0);
    cyc(0, 1, 2'd0, 1, 2, 0);
    cyc(1, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 22'd0) begin
      n_err++; $display("FAIL abort_nochg got=%h want=0", dut_vec());
    end
  endtask

`ifdef VEND_STOCK_COUNT_EN
  task automatic test_stock();
    cyc(1, 1, 2'd0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 1, 2'd3, 0, 0, 0);
      cyc(0, 1, 2'd1, 0, 0, 0);
      cyc(0, 1, 2'd0, 1, 2, 0);
      if (k == 15) begin
        n_cmp++;
        if (dut_vec() !== exp_vec() || bus.DENY !== 1'b1 || bus.CREDIT !== 8'd30) begin
          n_err++; $display("FAIL stock_deny got=%h want=%h", dut_vec(), exp_vec());
        end
        cyc(0, 1, 2'd0, 0, 0, 1);
      end else begin
        cyc(0, 1, 2'd0, 0, 0, 0);
      end
      cyc(0, 1, 2'd0, 0, 0, 0);
    end
    n_cmp++;
    if (bus.EMPTY !== 4'b0100) begin
      n_err++; $display("FAIL stock_empty got=%b want=0100", bus.EMPTY);
    end
    cyc(0, 1, 2'd0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.EMPTY !== 4'b0000) begin
      n_err++; $display("FAIL stock_restock got=%b want=0000", bus.EMPTY);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_cyc%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
`ifdef VEND_STOCK_COUNT_EN
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (bus.EMPTY[j] !== (m_stock[j] == 0)) begin
          n_err++; $display("FAIL random_empty%0d got=%b want=%b", j, bus.EMPTY[j], m_stock[j] == 0);
        end
      end
`endif
    end
  endtask

  initial begin
    bus.ST  = 1'b0;
    bus.CN  = 2'd0;
    bus.FS  = 1'b0;
    bus.SEL = 2'd0;
    bus.CAN = 1'b0;
`ifdef VEND_STOCK_COUNT_EN
    bus.RESTOCK = 1'b0;
`endif
    test_reset();
    test_basic_vend();
    test_deny();
    test_overcredit();
    test_cancel_abort();
`ifdef VEND_STOCK_COUNT_EN
    test_stock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
